newton_iter_ctrl: RTL and testbench

- Sequencing controller for Newton–Raphson integer square-root iteration: x_next = x - (x*x - b)/(x + x).
- Owns no arithmetic. Drives one shared valid/ready ALU (add/sub/mul/div) step by step, iterates until convergence or MAX_ITER, then returns the result over a valid/ready output port.
- Replaces the hand-wired per-operator handshake chain in the Newton datapath.

---
 rtl/newton_iter_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_newton_iter_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/newton_iter_ctrl.sv
// Sequencer for Newton-Raphson integer square root: x <- x - (x*x - b)/(x + x).
// Issues each step to one shared valid/ready ALU and returns the result over a valid/ready port.
module newton_iter_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ITER_W   = 4,
    parameter int MAX_ITER = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_vd,
    output logic              start_rd,
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] b_value,
    output logic              alu_in_vd,
    input  logic              alu_in_rd,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_out_vd,
    output logic              alu_out_rd,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_vd,
    input  logic              res_rd,
    output logic [DATA_W-1:0] res_x,
    output logic [ITER_W-1:0] res_iter,
    output logic              res_err,
    output logic              busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] t1_q, t1_d;
    logic [DATA_W-1:0] t2_q, t2_d;
    logic [DATA_W-1:0] t3_q, t3_d;
    logic [DATA_W-1:0] t4_q, t4_d;
    logic [DATA_W-1:0] xn_q, xn_d;
    logic [2:0]        step_q, step_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [DATA_W-1:0] res_x_q, res_x_d;
    logic [ITER_W-1:0] res_iter_q, res_iter_d;
    logic              res_err_q, res_err_d;

    logic [1:0]        op_sel;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic              div_zero;
    logic              issue_ok;
    logic [ITER_W-1:0] iter_inc;
    logic              iter_lim;

    // Step table: operation and operand selection for the current step.
    always_comb begin
        op_sel = OP_SUB;
        a_sel  = x_q;
        b_sel  = t4_q;
        case (step_q)
            3'd0: begin op_sel = OP_MUL; a_sel = x_q;  b_sel = x_q;  end
            3'd1: begin op_sel = OP_SUB; a_sel = t1_q; b_sel = b_q;  end
            3'd2: begin op_sel = OP_ADD; a_sel = x_q;  b_sel = x_q;  end
            3'd3: begin op_sel = OP_DIV; a_sel = t2_q; b_sel = t3_q; end
            default: ;
        endcase
    end

    // A zero divisor aborts the job before the DIV is ever offered to the ALU.
    assign div_zero = (step_q == 3'd3) && (t3_q == '0);
    assign issue_ok = (state_q == S_ISSUE) && !div_zero;
    assign iter_inc = iter_q + 1'b1;
    assign iter_lim = (iter_inc == ITER_W'(MAX_ITER));

    assign alu_in_vd  = issue_ok;
    assign alu_op     = issue_ok ? op_sel : 2'b00;
    assign alu_a      = issue_ok ? a_sel : '0;
    assign alu_b      = issue_ok ? b_sel : '0;
    assign alu_out_rd = (state_q == S_WAIT);
    assign start_rd   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign res_vd     = (state_q == S_DONE);
    assign res_x      = res_x_q;
    assign res_iter   = res_iter_q;
    assign res_err    = res_err_q;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        b_d        = b_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        t3_d       = t3_q;
        t4_d       = t4_q;
        xn_d       = xn_q;
        step_d     = step_q;
        iter_d     = iter_q;
        res_x_d    = res_x_q;
        res_iter_d = res_iter_q;
        res_err_d  = res_err_q;
        case (state_q)
            S_IDLE: begin
                if (start_vd) begin
                    x_d     = x0;
                    b_d     = b_value;
                    step_d  = 3'd0;
                    iter_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (div_zero) begin
                    res_x_d    = x_q;
                    res_iter_d = iter_q;
                    res_err_d  = 1'b1;
                    state_d    = S_DONE;
                end else if (alu_in_rd) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (alu_out_vd) begin
                    case (step_q)
                        3'd0:    t1_d = alu_result;
                        3'd1:    t2_d = alu_result;
                        3'd2:    t3_d = alu_result;
                        3'd3:    t4_d = alu_result;
                        default: xn_d = alu_result;
                    endcase
                    if (step_q == 3'd4) begin
                        state_d = S_CHECK;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_CHECK: begin
                iter_d = iter_inc;
                if ((xn_q == x_q) || iter_lim) begin
                    res_x_d    = xn_q;
                    res_iter_d = iter_inc;
                    res_err_d  = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    x_d     = xn_q;
                    step_d  = 3'd0;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                if (res_rd) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            b_q        <= '0;
            t1_q       <= '0;
            t2_q       <= '0;
            t3_q       <= '0;
            t4_q       <= '0;
            xn_q       <= '0;
            step_q     <= 3'd0;
            iter_q     <= '0;
            res_x_q    <= '0;
            res_iter_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            b_q        <= b_d;
            t1_q       <= t1_d;
            t2_q       <= t2_d;
            t3_q       <= t3_d;
            t4_q       <= t4_d;
            xn_q       <= xn_d;
            step_q     <= step_d;
            iter_q     <= iter_d;
            res_x_q    <= res_x_d;
            res_iter_q <= res_iter_d;
            res_err_q  <= res_err_d;
        end
    end

endmodule

// File: tb/tb_newton_iter_ctrl.sv
// Bench for newton_iter_ctrl: two instances (iteration limits 8 and 1), each with a stallable ALU model,
// checked against a plain-arithmetic Newton iteration model.
module tb_newton_iter_ctrl;

    localparam int DW = 8;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          start_vd   [2];
    logic          start_rd   [2];
    logic [DW-1:0] x0         [2];
    logic [DW-1:0] b_value    [2];
    logic          res_vd     [2];
    logic          res_rd     [2];
    logic [DW-1:0] res_x      [2];
    logic [IW-1:0] res_iter   [2];
    logic          res_err    [2];
    logic          busy       [2];
    logic          alu_in_vd  [2];
    logic          alu_out_rd [2];
    int            ops_cnt    [2];
    int            stall_pct  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] alu_f(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            2'b00:   alu_f = a + b;
            2'b01:   alu_f = a - b;
            2'b10:   alu_f = a * b;
            default: alu_f = (b == '0) ? '1 : a / b;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            logic          in_vd, in_rd, out_vd, out_rd, pend;
            logic [1:0]    op;
            logic [DW-1:0] a, b, result;
            int            dly;

            newton_iter_ctrl #(
                .DATA_W  (DW),
                .ITER_W  (IW),
                .MAX_ITER((gi == 0) ? 8 : 1)
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .start_vd  (start_vd[gi]),
                .start_rd  (start_rd[gi]),
                .x0        (x0[gi]),
                .b_value   (b_value[gi]),
                .alu_in_vd (in_vd),
                .alu_in_rd (in_rd),
                .alu_op    (op),
                .alu_a     (a),
                .alu_b     (b),
                .alu_out_vd(out_vd),
                .alu_out_rd(out_rd),
                .alu_result(result),
                .res_vd    (res_vd[gi]),
                .res_rd    (res_rd[gi]),
                .res_x     (res_x[gi]),
                .res_iter  (res_iter[gi]),
                .res_err   (res_err[gi]),
                .busy      (busy[gi])
            );

            assign alu_in_vd[gi]  = in_vd;
            assign alu_out_rd[gi] = out_rd;
            assign out_vd         = pend && (dly == 0);

            // ALU model: result valid the cycle after acceptance unless a random delay is drawn.
            always @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_rd       <= 1'b1;
                    pend        <= 1'b0;
                    dly         <= 0;
                    result      <= '0;
                    ops_cnt[gi] <= 0;
                end else begin
                    in_rd <= (int'($urandom_range(99, 0)) >= stall_pct[gi]);
                    if (out_vd && out_rd) begin
                        pend <= 1'b0;
                    end else if (pend && dly != 0) begin
                        dly <= dly - 1;
                    end
                    if (in_vd && in_rd) begin
                        result      <= alu_f(op, a, b);
                        pend        <= 1'b1;
                        dly         <= (stall_pct[gi] == 0) ? 0 : int'($urandom_range(3, 0));
                        ops_cnt[gi] <= ops_cnt[gi] + 1;
                    end
                end
            end

            logic          hold_in = 1'b0;
            logic          hold_res = 1'b0;
            logic [1:0]    p_op;
            logic [DW-1:0] p_a, p_b, p_rx;
            logic [IW-1:0] p_ri;
            logic          p_re;

            always @(negedge clk) begin
                if (!rst_n) begin
                    hold_in  <= 1'b0;
                    hold_res <= 1'b0;
                end else begin
                    if (hold_in) begin
                        check("alu_in_vd held", in_vd, 1);
                        check("alu_op held", op, p_op);
                        check("alu_a held", a, p_a);
                        check("alu_b held", b, p_b);
                    end
                    if (hold_res) begin
                        check("res_vd held", res_vd[gi], 1);
                        check("res_x held", res_x[gi], p_rx);
                        check("res_iter held", res_iter[gi], p_ri);
                        check("res_err held", res_err[gi], p_re);
                    end
                    hold_in  <= in_vd && !in_rd;
                    hold_res <= res_vd[gi] && !res_rd[gi];
                    p_op     <= op;
                    p_a      <= a;
                    p_b      <= b;
                    p_rx     <= res_x[gi];
                    p_ri     <= res_iter[gi];
                    p_re     <= res_err[gi];
                end
            end
        end
    endgenerate

    // Reference: the Newton iteration written as plain integer arithmetic mod 256.
    task automatic model(input logic [7:0] xs, input logic [7:0] bs, input int maxit,
                         output logic [7:0] rx, output int rit, output bit rerr,
                         output int rops, output int rlat);
        int x, b, t1, t2, t3, t4, xn, it;
        x = xs; b = bs; it = 0;
        rx = xs; rit = 0; rerr = 0; rops = 0; rlat = 0;
        for (int guard = 0; guard < 16; guard++) begin
            t1 = (x * x) % 256;
            t2 = (t1 - b + 256) % 256;
            t3 = (x + x) % 256;
            rops += 3;
            if (t3 == 0) begin
                rerr = 1; rx = 8'(x); rit = it; rlat = 11 * it + 8;
                return;
            end
            t4 = t2 / t3;
            xn = (x - t4 + 256) % 256;
            rops += 2;
            it++;
            if (xn == x || it == maxit) begin
                rx = 8'(xn); rit = it; rlat = 11 * it + 1;
                return;
            end
            x = xn;
        end
    endtask

    task automatic run_job(input int k, input logic [7:0] xs, input logic [7:0] bs, input int stall,
                           input bit pulse, output logic [7:0] gx, output logic [3:0] git,
                           output logic gerr, output int lat, output int nops);
        int  n, ops0;
        bit  done, seen;
        gx = '0; git = '0; gerr = 1'b0; lat = 0; nops = 0;
        stall_pct[k] = stall;
        @(posedge clk); #1;
        start_vd[k] = 1'b1; x0[k] = xs; b_value[k] = bs; res_rd[k] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!start_rd[k] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("start accepted", start_rd[k], 1);
        ops0 = ops_cnt[k];
        @(posedge clk); #1;
        // Scramble the job inputs so any late re-sampling shows up in the result.
        start_vd[k] = pulse;
        x0[k] = pulse ? 8'd1 : 8'($urandom);
        b_value[k] = pulse ? 8'd1 : 8'($urandom);
        res_rd[k] = (stall == 0) || (int'($urandom_range(99, 0)) >= stall);
        n = 0; done = 0; seen = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            if (pulse) check("start_rd while busy", start_rd[k], 0);
            if (res_vd[k] && !seen) begin
                seen = 1;
                lat = n + 1;
            end
            if (res_vd[k] && res_rd[k]) begin
                gx = res_x[k]; git = res_iter[k]; gerr = res_err[k];
                nops = ops_cnt[k] - ops0;
                done = 1;
            end
            @(posedge clk); n++; #1;
            if (!done) res_rd[k] = (stall == 0) || (int'($urandom_range(99, 0)) >= stall);
        end
        check("result handshake", done, 1);
        res_rd[k] = 1'b0;
        start_vd[k] = 1'b0;
    endtask

    task automatic do_job(input int k, input logic [7:0] xs, input logic [7:0] bs, input int stall,
                          input bit pulse);
        logic [7:0] ex, gx;
        logic [3:0] git;
        logic       gerr;
        bit         eerr;
        int         eit, eops, elat, glat, gops;
        model(xs, bs, (k == 0) ? 8 : 1, ex, eit, eerr, eops, elat);
        run_job(k, xs, bs, stall, pulse, gx, git, gerr, glat, gops);
        check("res_x", gx, ex);
        check("res_iter", git, eit);
        check("res_err", gerr, eerr);
        check("alu_issues", gops, eops);
        if (stall == 0) check("latency", glat, elat);
        $display("job inst=%0d x0=%0d b=%0d stall=%0d pulse=%0d -> res_x=%0d iter=%0d err=%0d ops=%0d lat=%0d (exp %0d/%0d/%0d/%0d/%0d)",
                 k, xs, bs, stall, pulse, gx, git, gerr, gops, glat, ex, eit, eerr, eops, elat);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            start_vd[k] = 1'b0; x0[k] = '0; b_value[k] = '0; res_rd[k] = 1'b0; stall_pct[k] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset start_rd", start_rd[0], 1);
        check("reset busy", busy[0], 0);
        check("reset res_vd", res_vd[0], 0);
        check("reset alu_in_vd", alu_in_vd[0], 0);
        check("reset alu_out_rd", alu_out_rd[0], 0);
        check("reset res_x", res_x[0], 0);
        check("reset res_iter", res_iter[0], 0);
        check("reset res_err", res_err[0], 0);
        @(negedge clk); #2;
        rst_n = 1'b1;

        // Convergence, iteration limit, divide-by-zero aborts, backpressure.
        do_job(0, 8'd8, 8'd16, 0, 1'b0);
        do_job(1, 8'd8, 8'd16, 0, 1'b0);
        do_job(0, 8'd0, 8'd9, 0, 1'b0);
        do_job(0, 8'd128, 8'd9, 0, 1'b0);
        do_job(0, 8'd8, 8'd16, 50, 1'b0);
        do_job(1, 8'd8, 8'd16, 60, 1'b0);

        // Reset during WAIT of iteration 1 step 2.
        stall_pct[0] = 0;
        @(posedge clk); #1;
        start_vd[0] = 1'b1; x0[0] = 8'd8; b_value[0] = 8'd16;
        @(negedge clk);
        check("midrst start_rd", start_rd[0], 1);
        @(posedge clk); #1;
        start_vd[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst in WAIT", alu_out_rd[0], 1);
        check("midrst busy before", busy[0], 1);
        rst_n = 1'b0;
        #1;
        check("midrst busy", busy[0], 0);
        check("midrst alu_in_vd", alu_in_vd[0], 0);
        check("midrst res_vd", res_vd[0], 0);
        check("midrst start_rd", start_rd[0], 1);
        $display("reset asserted mid-job: busy=%0d alu_in_vd=%0d res_vd=%0d start_rd=%0d",
                 busy[0], alu_in_vd[0], res_vd[0], start_rd[0]);
        @(negedge clk); #2;
        rst_n = 1'b1;
        do_job(0, 8'd8, 8'd16, 0, 1'b0);

        // Start request held while busy must not disturb the running job.
        do_job(0, 8'd8, 8'd16, 0, 1'b1);
        do_job(0, 8'd1, 8'd1, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            do_job(i % 2, 8'($urandom), 8'($urandom),
                   (i % 3 == 0) ? 0 : int'($urandom_range(60, 10)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
